// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA frame generator: display modes,
// default 640x480 timing, 3-bit RGB colour codes and glyph geometry.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_BLACK = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GLYPH = 2'd3
  } disp_mode_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // {R,G,B} bit codes
  localparam logic [2:0] C_WHITE   = 3'b111;
  localparam logic [2:0] C_YELLOW  = 3'b110;
  localparam logic [2:0] C_CYAN    = 3'b011;
  localparam logic [2:0] C_GREEN   = 3'b010;
  localparam logic [2:0] C_MAGENTA = 3'b101;
  localparam logic [2:0] C_RED     = 3'b100;
  localparam logic [2:0] C_BLUE    = 3'b001;
  localparam logic [2:0] C_BLACK   = 3'b000;

  localparam int GLYPH_SIZE = 256;

  function automatic logic [2:0] bar_color(input int bar);
    case (bar)
      0:       return C_WHITE;
      1:       return C_YELLOW;
      2:       return C_CYAN;
      3:       return C_GREEN;
      4:       return C_MAGENTA;
      5:       return C_RED;
      6:       return C_BLUE;
      default: return C_BLACK;
    endcase
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters for the VGA frame generator, with combinational sync
// decode and visible-area flag for the current counter position.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          hsync,
  output logic          vsync,
  output logic          visible
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pix_en) begin
      if (hcnt == HW'(H_TOTAL - 1)) begin
        hcnt <= '0;
        if (vcnt == VW'(V_TOTAL - 1)) vcnt <= '0;
        else                          vcnt <= vcnt + VW'(1);
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  always_comb begin
    hsync = !1'(SYNC_POL);
    vsync = !1'(SYNC_POL);
    if (hcnt >= HW'(H_ACTIVE + H_FP) && hcnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1))
      hsync = 1'(SYNC_POL);
    if (vcnt >= VW'(V_ACTIVE + V_FP) && vcnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1))
      vsync = 1'(SYNC_POL);
    visible = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  end

endmodule

// File: rtl/vga_frame_gen.sv
// Pipelined VGA frame generator: raster timing, frame-latched display modes
// and registered sync/colour outputs. Define VGA_PATTERN_EN to build bars/checkerboard.
module vga_frame_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int COLOR_W  = 4,
  parameter int SYNC_POL = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_en,
  input  logic [1:0]         mode,
  input  logic               char,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               active,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_OFF   = (H_ACTIVE - GLYPH_SIZE) / 2;
  localparam int V_OFF   = (V_ACTIVE - GLYPH_SIZE) / 2;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          t_hsync, t_vsync, visible;
  logic          frame_first;
  disp_mode_t    mode_sh, mode_eff;
  logic          char_sh, char_eff;
  logic [2:0]    rgb;
  int            dx, dy;
  logic          in_box;
`ifdef VGA_PATTERN_EN
  int            bar;
`endif

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .SYNC_POL (SYNC_POL)
  ) u_timing (
    .clk     (clk),
    .rst     (rst),
    .pix_en  (pix_en),
    .hcnt    (hcnt),
    .vcnt    (vcnt),
    .hsync   (t_hsync),
    .vsync   (t_vsync),
    .visible (visible)
  );

  assign frame_first = (hcnt == '0) && (vcnt == '0);

  always_comb begin
    // Pixel (0,0) uses the value being latched so the whole frame shares one mode.
    mode_eff = frame_first ? disp_mode_t'(mode) : mode_sh;
    char_eff = frame_first ? char : char_sh;
    dx       = int'(hcnt) - H_OFF;
    dy       = int'(vcnt) - V_OFF;
    in_box   = (dx >= 0) && (dx < GLYPH_SIZE) && (dy >= 0) && (dy < GLYPH_SIZE);
    rgb      = C_BLACK;
`ifdef VGA_PATTERN_EN
    bar = int'(hcnt) / (H_ACTIVE / 8);
    if (bar > 7) bar = 7;
`endif
    case (mode_eff)
`ifdef VGA_PATTERN_EN
      MODE_BARS:  rgb = bar_color(bar);
      MODE_CHECK: rgb = (hcnt[5] ^ vcnt[5]) ? C_WHITE : C_BLACK;
`endif
      MODE_GLYPH: begin
        if (in_box) begin
          if (!char_eff) begin
            if (iabs(dx - dy) < 4 || iabs(dx + dy - (GLYPH_SIZE - 1)) < 4) rgb = C_RED;
          end else begin
            if (dx < 8 || dx > GLYPH_SIZE - 9 || dy < 8 || dy > GLYPH_SIZE - 9) rgb = C_GREEN;
          end
        end
      end
      default: rgb = C_BLACK;
    endcase
    if (!visible) rgb = C_BLACK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sh     <= MODE_BLACK;
      char_sh     <= 1'b0;
      hsync       <= !1'(SYNC_POL);
      vsync       <= !1'(SYNC_POL);
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && frame_first;
      if (pix_en) begin
        if (frame_first) begin
          mode_sh <= disp_mode_t'(mode);
          char_sh <= char;
        end
        hsync  <= t_hsync;
        vsync  <= t_vsync;
        active <= visible;
        red    <= {COLOR_W{rgb[2]}};
        green  <= {COLOR_W{rgb[1]}};
        blue   <= {COLOR_W{rgb[0]}};
      end
    end
  end

endmodule
